// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, reads a synchronous ROM, buffers {pc, word} in a DEPTH-entry FIFO for decode (2-cycle fetch-to-valid).
// Requests stop while buffered + in-flight would exceed DEPTH; a redirect flushes the FIFO and any in-flight response.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   req_pc;
  logic          inflight;
  logic          kill;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   mem_pc   [DEPTH];
  logic [31:0]   mem_word [DEPTH];
  logic          deq;
  logic          push;
  logic [CW:0]   occ;

  assign instr_valid = (count != '0);
  assign instr       = mem_word[rd_ptr];
  assign instr_pc    = mem_pc[rd_ptr];
  assign imem_addr   = fetch_pc;

  // Occupancy counts the in-flight slot so a full FIFO can never be overrun by the ROM response.
  always_comb begin
    deq      = instr_valid && instr_ready;
    push     = inflight && !kill && !redirect;
    occ      = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(deq);
    imem_req = !reset && !redirect && (occ < (CW+1)'(DEPTH));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
      kill     <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc[i]   <= '0;
        mem_word[i] <= '0;
      end
    end else begin
      inflight <= imem_req;
      kill     <= redirect && inflight;
      if (imem_req) req_pc <= fetch_pc;
      if (redirect) begin
        fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
      end else begin
        if (imem_req) fetch_pc <= fetch_pc + 32'd4;
        if (push) begin
          mem_pc[wr_ptr]   <= req_pc;
          mem_word[wr_ptr] <= imem_rdata;
          wr_ptr           <= wr_ptr + AW'(1);
        end
        if (deq) rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(deq);
      end
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// Randomized and directed bench for fetch_stage against a stream-level model of expected pcs.
module tb_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  int total  = 0;
  int passed = 0;

  // Model: next pc to deliver, next pc to request, and fetches issued/delivered since the last flush.
  logic [31:0] exp_pc;
  logic [31:0] issue_pc;
  int          issued;
  int          delivered;
  int          since_rd;
  int          stall_cnt;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
  );

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'h1000_0000 + {2'b00, a[31:2]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_pc    = RESET_PC;
    issue_pc  = RESET_PC;
    issued    = 0;
    delivered = 0;
    since_rd  = 0;
    stall_cnt = 0;
  endtask

  // One clock cycle: drive inputs, check the settled cycle against the model, then clock the ROM.
  task automatic step(input logic rd, input logic [31:0] rpc, input logic rdy);
    logic        req_s;
    logic [31:0] addr_s;
    redirect    = rd;
    redirect_pc = rpc;
    instr_ready = rdy;
    #1;
    stall_cnt = rdy ? 0 : stall_cnt + 1;
    if (instr_valid) begin
      chk("head_pc", instr_pc, exp_pc);
      chk("head_word", instr, rom(exp_pc));
      if (rdy) begin
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
    end
    if (since_rd == 1 || since_rd == 2) chk("flush_valid", 32'(instr_valid), 32'd0);
    if (!rd && since_rd == 1) chk("redir_req", 32'(imem_req), 32'd1);
    if (!rd && since_rd == 3) chk("redir_valid", 32'(instr_valid), 32'd1);
    if (imem_req) begin
      chk("issue_addr", imem_addr, issue_pc);
      issue_pc = issue_pc + 32'd4;
      issued++;
    end
    chk("occupancy", 32'(issued - delivered <= DEPTH), 32'd1);
    if (stall_cnt >= 4 && since_rd == 0 && !rd) begin
      chk("stall_req", 32'(imem_req), 32'd0);
      chk("stall_valid", 32'(instr_valid), 32'd1);
    end
    if (rd) begin
      chk("redir_no_req", 32'(imem_req), 32'd0);
      exp_pc    = rpc & 32'hFFFF_FFFC;
      issue_pc  = exp_pc;
      issued    = 0;
      delivered = 0;
      since_rd  = 1;
    end else if (since_rd != 0) begin
      since_rd = (since_rd == 3) ? 0 : since_rd + 1;
    end
    req_s  = imem_req;
    addr_s = imem_addr;
    @(posedge clk);
    #1;
    imem_rdata = req_s ? rom(addr_s) : $urandom;
    @(negedge clk);
  endtask

  initial begin
    logic        rd;
    logic        rdy;
    logic [31:0] rpc;
    reset       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b0;
    imem_rdata  = '0;
    model_reset();
    #1 reset = 1'b1;
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, RESET_PC);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc", instr_pc, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Sequential stream: valid from cycle 2 with no gaps.
    for (int i = 0; i < 12; i++) begin
      chk("stream_valid", 32'(instr_valid), (i >= 2) ? 32'd1 : 32'd0);
      step(1'b0, 32'd0, 1'b1);
    end

    // Backpressure, then release.
    for (int i = 0; i < 8; i++) step(1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 1'b1);

    // Redirect with a full FIFO; low address bits are dropped.
    for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 1'b0);
    step(1'b1, 32'h0000_0103, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 32'd0, 1'b1);

    // Redirect in the same cycle as a completing handshake.
    chk("hs_valid", 32'(instr_valid), 32'd1);
    step(1'b1, 32'h0000_0200, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 32'd0, 1'b1);

    // Address wrap-around through 0xFFFF_FFFC.
    step(1'b1, 32'hFFFF_FFF8, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 32'd0, 1'b1);

    // Back-to-back redirects: last one wins.
    step(1'b1, 32'h0000_4000, 1'b1);
    step(1'b1, 32'h0000_8000, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 32'd0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      rd  = ($urandom_range(0, 19) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      rpc = $urandom;
      step(rd, rpc, rdy);
    end

    // Reset asserted between edges with a request in flight.
    for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b1);
    redirect    = 1'b0;
    instr_ready = 1'b1;
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("mid_rst_req", 32'(imem_req), 32'd0);
    chk("mid_rst_addr", imem_addr, RESET_PC);
    chk("mid_rst_valid", 32'(instr_valid), 32'd0);
    chk("mid_rst_instr", instr, 32'd0);
    chk("mid_rst_pc", instr_pc, 32'd0);
    imem_rdata = $urandom;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      chk("post_rst_valid", 32'(instr_valid), (i >= 2) ? 32'd1 : 32'd0);
      step(1'b0, 32'd0, 1'b1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage that sits directly upstream of the single-cycle core datapath. It owns the program counter, issues word reads to the synchronous instruction ROM, and buffers returned words with their PCs in a small FIFO. It presents them to decode through a valid/ready handshake. Taken branches and jumps from the execute side redirect it, which flushes every buffered and in-flight fetch.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- DEPTH, 2: fetch FIFO entries; a power of two, at least 2.

- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- imem_req  out  1  read request to the instruction ROM this cycle.
- imem_addr  out  32  byte address of the request; bits [1:0] are always 0.
- imem_rdata  in  32  ROM data; valid exactly 1 cycle after the cycle in which imem_req=1.
- redirect  in  1  taken branch or jump; one-cycle pulse.
- redirect_pc  in  32  redirect target; bits [1:0] are ignored and forced to 0.
- instr_valid  out  1  FIFO head is valid.
- instr  out  32  FIFO head instruction word.
- instr_pc  out  32  byte address of instr.
- instr_ready  in  1  decode accepts the head this cycle.

## Operation
- State:
  - fetch_pc (32): next address to request.
  - inflight (1): a request was issued last cycle.
  - kill (1): drop the response arriving this cycle.
  - FIFO of DEPTH × {pc, word}, with read/write pointers and a count.
- Issue rule: imem_req = !redirect && (count + inflight − deq < DEPTH), where deq = instr_valid && instr_ready.
- On issue: imem_addr = fetch_pc, then fetch_pc ← fetch_pc + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
- Response: when inflight=1 and kill=0, push {pc of that request, imem_rdata}. The issue rule guarantees the FIFO never overflows; push is never dropped for lack of space.
- Handshake: deq pops the head. Push and pop in the same cycle leave count unchanged. When instr_valid=1 and instr_ready=0, instr and instr_pc hold stable.
- Redirect (cycle N):
  - A handshake completing in cycle N is honoured; that is the branch itself.
  - At the N edge:
    - All FIFO entries are flushed and count is set to 0.
    - fetch_pc ← {redirect_pc[31:2], 2'b00}.
    - kill ← inflight.
  - imem_req=0 in cycle N.
- Redirect on consecutive cycles: the last one wins, and each one re-flushes.
- instr_valid = (count != 0). It never depends combinationally on instr_ready.
- Reset values:
  - Outputs: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
  - Internal state: fetch_pc=RESET_PC, inflight=0, kill=0, count=0.
- Reset mid-operation:
  - Any in-flight response is discarded.
  - The first request after deassertion goes to RESET_PC, never a stale address.

## Timing
- Cycle 0 is the first edge with reset low. imem_req=1 with imem_addr=RESET_PC in cycle 0.
- The word is pushed at the end of cycle 1 and instr_valid=1 in cycle 2. Fetch-to-valid latency is 2 cycles.
- Throughput is 1 instruction per cycle with DEPTH=2 and instr_ready held at 1.
- Redirect in cycle N:
  - instr_valid=0 from N+1.
  - Request to the target in N+1.
  - Target instruction valid in N+3.
  - Redirect penalty: 3 cycles.
- Stall: with instr_ready=0, at most DEPTH entries plus 0 outstanding requests. Requests stop once count + inflight = DEPTH.
- The killed response in cycle N+1 must never appear at the output.

## Test plan
- Sequential stream: ROM word i = 32'h1000_0000+i, RESET_PC=0, instr_ready=1 → from cycle 2, one instr per cycle with instr_pc 0,4,8,…; instr=32'h1000_0000,…_0001,…; no gaps.
- Backpressure: instr_ready=0 for cycles 2–9 → exactly DEPTH=2 entries buffered, imem_req=0 after the FIFO fills, and head pc=0 held stable. On release, pcs continue 0,4,8 with no loss or duplication.
- Redirect flush: redirect=1, redirect_pc=32'h0000_0103 at cycle 5 with full FIFO → instr_valid=0 in cycles 6–7, imem_addr=32'h100 in cycle 6, and the next instr_pc is 32'h100. No pre-redirect pc appears.
- Redirect with handshake: redirect and instr_valid&instr_ready in the same cycle, head pc=8 → pc 8 is consumed exactly once, pc 12 is never delivered, and the next delivered pc is the target.
- Wrap-around: RESET_PC=32'hFFFF_FFF8 → delivered pcs are FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Reset mid-operation: assert reset asynchronously between edges while a request is in flight, hold it 2 cycles, then release → outputs go to reset values immediately. The first post-reset instr_pc is RESET_PC and the stale response is never pushed.
